serial_adder_n: RTL and testbench

- Parametrised bit-serial add/subtract unit: the WIDTH-bit successor of the team's 1-bit full-adder cell.
- Operands are captured on a start strobe and processed LSB-first, one bit per clock, through a single full-adder slice with a registered carry.
- Produces sum, carry-out and signed-overflow with a start/busy/done handshake.
- Sits behind the top-level tt_um_* wrapper, driven from ui_in/uio_in control and data pins.

---
 rtl/serial_adder_n_if.sv | 26 ++
 rtl/serial_adder_n.sv | 124 ++++++++++++
 tb/tb_serial_adder_n.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_n_if.sv
// Handshake and data bundle for the bit-serial add/subtract unit.
// The master side issues operations; the slave side is the adder itself.
interface serial_adder_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a_in, b_in,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a_in, b_in,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder slice, LSB first, one bit per clock.
// Results, carry-out and signed overflow are published only on the cycle the operation completes.
module serial_adder_n #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_n_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returns {carry, sum} of a single full-adder slice.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       fa_s;

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ps_d    = ps_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        fa_s    = full_add(sa_q[0], sb_q[0], c_q);

        case (state_q)
            IDLE, DONE: begin
                // Subtraction is A + ~B + ~borrow, so B and the carry are inverted at load time.
                if (bus.start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    sa_d    = bus.a_in;
                    sb_d    = bus.b_in ^ {WIDTH{bus.sub}};
                    c_d     = bus.cin ^ bus.sub;
                    ps_d    = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                ps_d  = {fa_s[0], ps_q[WIDTH-1:1]};
                c_d   = fa_s[1];
                cnt_d = cnt_q + CW'(1);
                // On the MSB slice c_q is the carry into the MSB, fa_s[1] the carry out of it.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    sum_d   = ps_d;
                    cout_d  = fa_s[1];
                    ovf_d   = c_q ^ fa_s[1];
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= {WIDTH{1'b0}};
            sb_q    <= {WIDTH{1'b0}};
            ps_q    <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ps_q    <= ps_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n at WIDTH=8 and WIDTH=16, against an arithmetic reference model.
module tb_serial_adder_n;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    serial_adder_n_if #(.WIDTH(8))  if8  ();
    serial_adder_n_if #(.WIDTH(16)) if16 ();

    serial_adder_n #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_adder_n #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {ovf, cout, sum} from plain modular arithmetic.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic ci, input logic sb);
        longint unsigned mask, av, bv, full;
        logic ov;
        mask = (64'd1 << w) - 64'd1;
        av   = {32'd0, a} & mask;
        bv   = {32'd0, b} & mask;
        if (sb) bv = ~bv & mask;
        full = av + bv + {63'd0, ci ^ sb};
        ov   = (av[w-1] == bv[w-1]) && (full[w-1] != av[w-1]);
        return {ov, full[w], full[31:0] & mask[31:0]};
    endfunction

    // Timing model: an accepted op completes WIDTH edges later; outputs hold in between.
    int          m_rem  [2];
    logic        m_busy [2];
    logic        m_done [2];
    logic [33:0] m_out  [2];
    logic [33:0] m_pend [2];
    int          m_acc  [2];

    task automatic model_reset(input int d);
        m_rem[d]  = 0;
        m_busy[d] = 1'b0;
        m_done[d] = 1'b0;
        m_out[d]  = 34'd0;
    endtask

    task automatic model_step(input int d, input int w, input logic st, input logic sb,
                              input logic ci, input logic [31:0] a, input logic [31:0] b);
        m_done[d] = 1'b0;
        if (m_rem[d] > 0) begin
            m_rem[d]--;
            if (m_rem[d] == 0) begin
                m_done[d] = 1'b1;
                m_busy[d] = 1'b0;
                m_out[d]  = m_pend[d];
            end
        end else if (st) begin
            m_rem[d]  = w;
            m_busy[d] = 1'b1;
            m_pend[d] = ref_op(w, a, b, ci, sb);
            m_acc[d]++;
        end else begin
            m_busy[d] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset(0);
        else model_step(0, 8, if8.start, if8.sub, if8.cin, {24'd0, if8.a_in}, {24'd0, if8.b_in});
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset(1);
        else model_step(1, 16, if16.start, if16.sub, if16.cin, {16'd0, if16.a_in}, {16'd0, if16.b_in});
    end

    task automatic cmp(input int d, input string tag, input logic b, input logic dn,
                       input logic co, input logic ov, input logic [31:0] s);
        check({tag, "_busy"}, {31'd0, b},  {31'd0, m_busy[d]});
        check({tag, "_done"}, {31'd0, dn}, {31'd0, m_done[d]});
        check({tag, "_sum"},  s,           m_out[d][31:0]);
        check({tag, "_cout"}, {31'd0, co}, {31'd0, m_out[d][32]});
        check({tag, "_ovf"},  {31'd0, ov}, {31'd0, m_out[d][33]});
        check({tag, "_done_and_busy"}, {31'd0, b & dn}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, "w8",  if8.busy,  if8.done,  if8.cout,  if8.ovf,  {24'd0, if8.sum});
            cmp(1, "w16", if16.busy, if16.done, if16.cout, if16.ovf, {16'd0, if16.sum});
        end
    end

    // One WIDTH=8 op with literal expectations for latency, busy length and result.
    task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic sb, input logic [7:0] es, input logic ec, input logic eo);
        int lat = 0;
        int bcnt = 0;
        bit seen = 1'b0;
        @(negedge clk);
        if8.start = 1'b1; if8.a_in = a; if8.b_in = b; if8.cin = ci; if8.sub = sb;
        @(posedge clk); #1;
        if (if8.busy) bcnt++;
        @(negedge clk);
        if8.start = 1'b0; if8.a_in = 8'($urandom); if8.b_in = 8'($urandom);
        if8.cin = 1'($urandom); if8.sub = 1'($urandom);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (if8.done) seen = 1'b1;
            else if (if8.busy) bcnt++;
        end
        check({nm, "_latency"}, 32'(lat), 32'd8);
        check({nm, "_busycycles"}, 32'(bcnt), 32'd8);
        check({nm, "_sum"},  {24'd0, if8.sum}, {24'd0, es});
        check({nm, "_cout"}, {31'd0, if8.cout}, {31'd0, ec});
        check({nm, "_ovf"},  {31'd0, if8.ovf},  {31'd0, eo});
    endtask

    task automatic wait_done8(input string nm, output int edges);
        bit seen = 1'b0;
        edges = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            edges++;
            if (if8.done) seen = 1'b1;
        end
        check({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic drive_rand(input int d);
        int cyc = 0;
        m_acc[d] = 0;
        while (m_acc[d] < 1000 && cyc < 40000) begin
            @(negedge clk);
            if (d == 0) begin
                if8.start = ($urandom_range(0, 3) != 0);
                if8.a_in = 8'($urandom); if8.b_in = 8'($urandom);
                if8.cin = 1'($urandom); if8.sub = 1'($urandom);
            end else begin
                if16.start = ($urandom_range(0, 3) != 0);
                if16.a_in = 16'($urandom); if16.b_in = 16'($urandom);
                if16.cin = 1'($urandom); if16.sub = 1'($urandom);
            end
            cyc++;
        end
        @(negedge clk);
        if (d == 0) if8.start = 1'b0;
        else if16.start = 1'b0;
        check(d == 0 ? "rand_ops_w8" : "rand_ops_w16", {31'd0, m_acc[d] >= 1000}, 32'd1);
    endtask

    initial begin
        int gap;
        int dummy;
        if8.start = 1'b0; if8.sub = 1'b0; if8.cin = 1'b0; if8.a_in = 8'd0; if8.b_in = 8'd0;
        if16.start = 1'b0; if16.sub = 1'b0; if16.cin = 1'b0; if16.a_in = 16'd0; if16.b_in = 16'd0;
        m_acc[0] = 0; m_acc[1] = 0;
        m_pend[0] = 34'd0; m_pend[1] = 34'd0;
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", {31'd0, if8.busy}, 32'd0);
        check("reset_done", {31'd0, if8.done}, 32'd0);
        check("reset_sum",  {24'd0, if8.sum},  32'd0);
        check("reset_cout_ovf", {30'd0, if16.cout, if16.ovf}, 32'd0);
        chk_en = 1'b1;

        run8("add_5a_3c",   8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1);
        run8("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("sub_10_20",   8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        run8("sub_80_01",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        run8("sub_05_05_b", 8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);

        // A start pulse during RUN cycle 3 must be ignored.
        @(negedge clk);
        if8.start = 1'b1; if8.a_in = 8'h12; if8.b_in = 8'h34; if8.cin = 1'b0; if8.sub = 1'b0;
        @(posedge clk);
        @(negedge clk); if8.start = 1'b0;
        @(negedge clk);
        @(negedge clk); if8.start = 1'b1; if8.a_in = 8'hFF; if8.b_in = 8'hFF; if8.sub = 1'b1;
        @(negedge clk); if8.start = 1'b0;
        check("ignored_hold_sum", {24'd0, if8.sum}, 32'h0000_00FF);
        wait_done8("ignored", dummy);
        check("ignored_sum", {24'd0, if8.sum}, 32'h0000_0046);

        // start held through DONE launches a second op; done pulses 9 cycles apart.
        @(negedge clk);
        if8.start = 1'b1; if8.a_in = 8'h01; if8.b_in = 8'h02; if8.cin = 1'b0; if8.sub = 1'b0;
        wait_done8("b2b_first", dummy);
        check("b2b_first_sum", {24'd0, if8.sum}, 32'h0000_0003);
        @(negedge clk);
        if8.a_in = 8'h03; if8.b_in = 8'h04;
        @(negedge clk);
        if8.start = 1'b0;
        wait_done8("b2b_second", gap);
        check("b2b_gap", 32'(gap + 1), 32'd9);
        check("b2b_second_sum", {24'd0, if8.sum}, 32'h0000_0007);

        // Asynchronous reset between edges at RUN cycle 4 discards the op.
        @(negedge clk);
        if8.start = 1'b1; if8.a_in = 8'h5A; if8.b_in = 8'h3C; if8.sub = 1'b0;
        @(posedge clk);
        @(negedge clk); if8.start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {if8.busy, if8.done, if8.cout, if8.ovf, 20'd0, if8.sum}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run8("after_rst", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);

        fork
            drive_rand(0);
            drive_rand(1);
        join
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
